// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and helpers for the 1-to-4 registered
//                demultiplexer (channel count, select width, counter width,
//                one-hot channel-enable decode).
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    // Decode a channel select into a one-hot enable vector.
    function automatic logic [NUM_CH-1:0] ch_enable(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1_4_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_4_if
//  Description : Handshake bundle of the 1-to-4 demultiplexer.
//                Producer side : in_valid, in_ready, in_sel, in_data
//                Consumer side : out_valid[3:0], out_ready[3:0], d0..d3
//                master = environment (producer + consumers), slave = demux.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_1_4_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready;
    logic [WIDTH-1:0]     d0;
    logic [WIDTH-1:0]     d1;
    logic [WIDTH-1:0]     d2;
    logic [WIDTH-1:0]     d3;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, d0, d1, d2, d3
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, d0, d1, d2, d3
    );

endinterface
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : One-entry holding register for a single output channel.
//                Ports : clk, rst       - clock / sync active-high reset
//                        load          - accept load_data this cycle
//                        load_data     - word to store
//                        ready_in      - consumer takes the word this cycle
//                        valid_out     - slot holds a word
//                        data_out      - held word (keeps last value when empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_data,
    input  wire logic             ready_in,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      data_out
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            // A load wins over a same-cycle drain: the slot refills in place.
            r_full <= 1'b1;
            r_data <= load_data;
        end else if (r_full && ready_in) begin
            r_full <= 1'b0;
        end
    end

    assign valid_out = r_full;
    assign data_out  = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_1_4.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1_4
//  Description : Registered 1-to-4 demultiplexer with valid/ready handshake.
//                The input word is steered by in_sel into one of four
//                one-entry channel buffers; each channel drains on its own.
//                Ports : clk, rst  - clock / sync active-high reset
//                        bus       - demux_1_4_if.slave handshake bundle
//                        cnt       - (DEMUX_1_4_CNT_EN only) four 8-bit
//                                    wrapping output-transfer counters,
//                                    channel k in cnt[8k+7:8k]
//                Build option : DEMUX_1_4_CNT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1_4
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
`ifdef DEMUX_1_4_CNT_EN
    output logic [NUM_CH*CNT_W-1:0]   cnt,
`endif
    demux_1_4_if.slave                bus
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_load;
    logic              w_in_ready;
    logic [WIDTH-1:0]  w_data [NUM_CH];

    // Ready only looks at the addressed channel: it can take a word if it is
    // empty or is being drained this very cycle.
    assign w_in_ready = ~w_full[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign w_load     = ch_enable(bus.in_sel) & {NUM_CH{bus.in_valid & w_in_ready}};

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            demux_slot #(
                .WIDTH     (WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[k]),
                .load_data (bus.in_data),
                .ready_in  (bus.out_ready[k]),
                .valid_out (w_full[k]),
                .data_out  (w_data[k])
            );
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_full;
    assign bus.d0        = w_data[0];
    assign bus.d1        = w_data[1];
    assign bus.d2        = w_data[2];
    assign bus.d3        = w_data[3];

`ifdef DEMUX_1_4_CNT_EN
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Natural 8-bit overflow gives the 255 -> 0 wrap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_full[k] && bus.out_ready[k]) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign cnt[k*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1_4
//  Description : Self-checking bench for demux_1_4: vector table for the
//                streaming case, hand sequences for stall / isolation /
//                mid-stream reset / counter wrap, and a per-channel queue
//                scoreboard sampling every cycle just before the clock edge.
//                Build option : DEMUX_1_4_CNT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_4;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
`ifdef DEMUX_1_4_CNT_EN
    logic [31:0] cnt;
`endif

    demux_1_4_if #(.WIDTH(WIDTH)) bus ();

    demux_1_4 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef DEMUX_1_4_CNT_EN
        .cnt   (cnt),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dk(input int k);
        case (k)
            0:       return bus.d0;
            1:       return bus.d1;
            2:       return bus.d2;
            default: return bus.d3;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: words pushed per channel on input transfer, popped and
    // compared on output transfer. Sampled 1 time unit before each edge.
    // ------------------------------------------------------------------
    logic [7:0] sb [4][$];
    logic [7:0] last_ld [4];
    logic [7:0] m_cnt [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            last_ld[k] = 8'h00;
            m_cnt[k]   = 8'h00;
        end
    end

    always begin
        logic [7:0] w;
        logic       exp_rdy;
        @(posedge clk);
        #9;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sb_out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(sb[k].size() != 0));
            chk($sformatf("sb_d%0d", k), 32'(dk(k)), 32'(last_ld[k]));
        end
        exp_rdy = (sb[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel];
        chk("sb_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
`ifdef DEMUX_1_4_CNT_EN
        chk("sb_cnt", cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
`endif
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                sb[k].delete();
                last_ld[k] = 8'h00;
                m_cnt[k]   = 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("sb_underflow[%0d]", k), 32'd1, 32'd0);
                    end else begin
                        w = sb[k].pop_front();
                        chk($sformatf("sb_pop_d%0d", k), 32'(dk(k)), 32'(w));
                    end
                    m_cnt[k] = m_cnt[k] + 8'd1;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb[bus.in_sel].push_back(bus.in_data);
                last_ld[bus.in_sel] = bus.in_data;
                chk("sb_depth", 32'(sb[bus.in_sel].size()), 32'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{1'b1, 2'd0, 8'h5A, 4'hF, 1'b1, 4'b0001};
        tbl[1] = '{1'b1, 2'd1, 8'hF0, 4'hF, 1'b1, 4'b0010};
        tbl[2] = '{1'b1, 2'd2, 8'h00, 4'hF, 1'b1, 4'b0100};
        tbl[3] = '{1'b1, 2'd3, 8'hC3, 4'hF, 1'b1, 4'b1000};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_d0", 32'(bus.d0), 32'h0);
        chk("rst_d1", 32'(bus.d1), 32'h0);
        chk("rst_d2", 32'(bus.d2), 32'h0);
        chk("rst_d3", 32'(bus.d3), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef DEMUX_1_4_CNT_EN
        chk("rst_cnt", cnt, 32'h0);
`endif

        // Streaming through all four channels
        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
            edge1();
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].v)
                chk($sformatf("tbl%0d_data", i), 32'(dk(int'(tbl[i].sel))), 32'(tbl[i].data));
        end

        // Channel 2 stall and pass-through refill
        cyc(1'b1, 2'd2, 8'h11, 4'b0000);
        chk("stall_first_rdy", 32'(bus.in_ready), 32'h1);
        edge1();
        chk("stall_ov_a", 32'(bus.out_valid), 32'b0100);
        chk("stall_d2_a", 32'(bus.d2), 32'h11);
        cyc(1'b1, 2'd2, 8'h22, 4'b0000);
        chk("stall_rdy_low", 32'(bus.in_ready), 32'h0);
        edge1();
        chk("stall_d2_hold", 32'(bus.d2), 32'h11);
        cyc(1'b1, 2'd2, 8'h22, 4'b0100);
        chk("stall_rdy_release", 32'(bus.in_ready), 32'h1);
        edge1();
        chk("stall_ov_b", 32'(bus.out_valid), 32'b0100);
        chk("stall_d2_b", 32'(bus.d2), 32'h22);
        cyc(1'b0, 2'd0, 8'h00, 4'b1111);
        edge1();
        chk("stall_drain_ov", 32'(bus.out_valid), 32'b0000);
        chk("stall_d2_kept", 32'(bus.d2), 32'h22);

        // Isolation: channel 1 stalled, write to channel 3
        cyc(1'b1, 2'd1, 8'h33, 4'b0000);
        edge1();
        cyc(1'b1, 2'd1, 8'h77, 4'b0000);
        chk("iso_sel1_blocked", 32'(bus.in_ready), 32'h0);
        cyc(1'b1, 2'd3, 8'hAA, 4'b0000);
        chk("iso_sel3_rdy", 32'(bus.in_ready), 32'h1);
        edge1();
        chk("iso_ov", 32'(bus.out_valid), 32'b1010);
        chk("iso_d1", 32'(bus.d1), 32'h33);
        chk("iso_d3", 32'(bus.d3), 32'hAA);

        // Fill remaining channels, then reset mid-stream
        cyc(1'b1, 2'd0, 8'h44, 4'b0000);
        edge1();
        cyc(1'b1, 2'd2, 8'h55, 4'b0000);
        edge1();
        chk("full_ov", 32'(bus.out_valid), 32'b1111);
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        edge1();
        chk("mrst_ov", 32'(bus.out_valid), 32'h0);
        chk("mrst_data", {bus.d3, bus.d2, bus.d1, bus.d0}, 32'h0);
`ifdef DEMUX_1_4_CNT_EN
        chk("mrst_cnt", cnt, 32'h0);
`endif
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'h1);

        // 257 transfers on channel 0 (counter wrap when enabled)
        for (int i = 0; i < 257; i++) begin
            cyc(1'b1, 2'd0, 8'(i), 4'b1111);
            edge1();
        end
        cyc(1'b0, 2'd0, 8'h00, 4'b1111);
        edge1();
        chk("wrap_ov", 32'(bus.out_valid), 32'h0);
        chk("wrap_d0", 32'(bus.d0), 32'h00);
`ifdef DEMUX_1_4_CNT_EN
        chk("wrap_cnt", cnt, 32'h0000_0001);
`endif

        cyc(1'b0, 2'd0, 8'h00, 4'b0000);
        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
